mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencer that computes a 32x32 multiply using one shared 16x16 unsigned registered multiplier cell, issuing four partial products over consecutive cycles.
- Accumulates the partial products into a 64-bit value, then applies signed correction.
- Returns the low or high word selected by the op code, using a valid/ready request/response handshake.
- Sits between the CPU custom-instruction/ALU front end and the multiplier cell; it is the sole driver of the cell's operand ports.

Parameters:
- MULT_LATENCY, 1: cycles from the operand pair on mc_dataa/mc_datab to the product on mc_result; legal range 1-3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_op  in  2  00 MUL (low word); 01 MULXSS (high, signed x signed); 10 MULXSU (high, A signed x B unsigned); 11 MULXUU (high, unsigned)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  result word
- busy  out  1  high whenever state is not IDLE
- mc_dataa  out  16  multiplier cell operand A
- mc_datab  out  16  multiplier cell operand B
- mc_result  in  32  multiplier cell unsigned product, MULT_LATENCY cycles after its operands

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: all state is reset on the clk edge at which reset=1, and reset has priority over every other event.
- Reset values: state=IDLE, rsp_valid=0, rsp_result=0, mc_dataa=0, mc_datab=0, busy=0, accumulator=0, in-flight tag pipeline cleared. req_ready=0 while reset=1.
- Handshake: req_ready = (state==IDLE) & ~reset. A request is accepted on an edge where req_valid & req_ready; call that edge T. Operands and op are latched at T.
- States: IDLE -> ISSUE -> DRAIN -> FIX -> RESP -> IDLE.
- ISSUE (cycles T+1..T+4): one partial product per cycle, driven as registered operand outputs, in this order:
  - pp0 = a[15:0] x b[15:0]
  - pp1 = a[31:16] x b[15:0]
  - pp2 = a[15:0] x b[31:16]
  - pp3 = a[31:16] x b[31:16]
- In-flight tracking: a tag/valid shift register of depth MULT_LATENCY follows each issued product. When a tagged result returns on mc_result, it is added to the 64-bit accumulator at shift 0 (pp0), 16 (pp1, pp2) or 32 (pp3), modulo 2^64.
- DRAIN: wait until the tag pipeline is empty. mc_dataa and mc_datab return to 0 after the last issue.
- FIX (1 cycle): signed correction of the high word, modulo 2^32:
  - if the op treats A as signed and a[31]=1, high -= b
  - if the op treats B as signed and b[31]=1, high -= a
  - No correction for MUL; the low word is sign-independent.
- RESP: rsp_result = low word for op 00, high word otherwise.
  - rsp_valid rises at T+MULT_LATENCY+6 (T+7 for latency 1).
  - rsp_valid and rsp_result are held stable until rsp_valid & rsp_ready.
  - After the completing edge: rsp_valid=0, state=IDLE, and req_ready=1 in the next cycle.
- No overlap: a new request cannot be accepted until the cycle after the response completes. req_valid is ignored while busy.
- Reset mid-operation: the operation is abandoned. Products still in the multiplier cell are ignored because their tags are cleared. No stale data reaches the next operation.
- Operand edge cases: a=0 or b=0 gives result 0, with the full latency still taken. Operands equal to 0x80000000 are handled by the correction rule without special-casing.

Optional Feature:
- Macro: MUL_SEQ_SHORTCUT_EN
- Defined: for op 00 (MUL) the block skips pp3, because it cannot affect the low word. ISSUE lasts 3 cycles and rsp_valid rises at T+MULT_LATENCY+5. Other ops are unchanged.
- Undefined: all ops issue 4 products with uniform latency T+MULT_LATENCY+6.

Test Plan:
All scenarios use MULT_LATENCY=1; the macro is undefined unless stated.
1. MUL a=0x00012345 b=0x00000010 -> rsp_result=0x00123450, rsp_valid first high at T+7; exactly 4 non-idle operand cycles on mc_dataa/mc_datab.
2. MULXUU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE. MULXSS a=0xFFFFFFFF b=0x00000002 -> 0xFFFFFFFF.
3. MULXSU a=0x80000000 b=0xFFFFFFFF -> 0x80000000. MULXSS a=0x80000000 b=0x80000000 -> 0x40000000.
4. Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result stable, req_ready=0, and a pulse on req_valid is not accepted; rsp_ready=1 -> req_ready=1 in the next cycle.
5. Assert reset for one edge at T+3 -> next cycle busy=0, rsp_valid=0. Then MULXUU a=0x00010000 b=0x00010000 -> 0x00000001, with no contamination from the aborted operation.
6. Macro defined: MUL a=0x0000FFFF b=0x0000FFFF -> 0xFFFE0001 at T+6 with 3 issue cycles. MULXUU on the same operands -> 0x00000000 at T+7.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 multiply sequencer built around one shared 16x16
// unsigned registered multiplier cell. Four partial products are issued on
// consecutive cycles and tracked by a tag pipeline. Returned products are
// summed into a 64-bit accumulator, and the high word gets a signed correction
// before the selected word is returned over a valid/ready handshake.
//
// Optional feature macro: MUL_SEQ_SHORTCUT_EN
//   defined   - op 00 (MUL) skips pp3, which cannot affect the low word
//   undefined - every op issues all four partial products
module mul_seq_ctrl #(
   parameter int MULT_LATENCY = 1   // cell latency, legal range 1-3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [1:0]  req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        busy,
   output logic [15:0] mc_dataa,
   output logic [15:0] mc_datab,
   input  logic [31:0] mc_result
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      FIX   = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] a_reg, b_reg;
   logic [1:0]  op_reg;
   logic [1:0]  cnt_reg;          // index of the next partial product to issue
   logic [63:0] acc_reg;
   logic        rsp_valid_reg;
   logic [31:0] rsp_result_reg;
   logic [15:0] mc_dataa_reg, mc_datab_reg;

   // Stage aligned with the operand registers, then one stage per cell cycle
   // so the last stage lines up with the product on mc_result.
   logic        iss_vld_reg;
   logic [1:0]  iss_tag_reg;
   logic        tag_vld_reg [MULT_LATENCY];
   logic [1:0]  tag_reg     [MULT_LATENCY];

   logic        accept;
   logic [1:0]  last_idx;
   logic        issue_en;
   logic [1:0]  issue_idx;
   logic [31:0] src_a, src_b;
   logic [15:0] issue_a, issue_b;
   logic        pipe_empty;
   logic        ret_vld;
   logic [1:0]  ret_tag;
   logic [63:0] pp_shifted;
   logic        a_signed, b_signed;
   logic [31:0] corr_a, corr_b;
   logic [31:0] hi_fixed;
   logic [31:0] result_word;

   assign req_ready  = (state_reg == IDLE) & ~reset;
   assign accept     = req_valid & req_ready;
   assign busy       = (state_reg != IDLE);
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign mc_dataa   = mc_dataa_reg;
   assign mc_datab   = mc_datab_reg;
   assign ret_vld    = tag_vld_reg[MULT_LATENCY-1];
   assign ret_tag    = tag_reg[MULT_LATENCY-1];

`ifdef MUL_SEQ_SHORTCUT_EN
   // The low word never sees pp3, so MUL stops after pp2.
   assign last_idx = (op_reg == OP_MUL) ? 2'd2 : 2'd3;
`else
   assign last_idx = 2'd3;
`endif

   // Pick the operand halves for this cycle; pp0 is issued straight from the
   // request on the accepting edge so the cell starts without a bubble.
   always_comb begin
      issue_en  = 1'b0;
      issue_idx = 2'd0;
      src_a     = a_reg;
      src_b     = b_reg;
      if (state_reg == IDLE) begin
         issue_en = accept;
         src_a    = req_a;
         src_b    = req_b;
      end else if (state_reg == ISSUE) begin
         issue_en  = 1'b1;
         issue_idx = cnt_reg;
      end
      issue_a = issue_idx[0] ? src_a[31:16] : src_a[15:0];
      issue_b = issue_idx[1] ? src_b[31:16] : src_b[15:0];
   end

   // Nothing issued and nothing in flight.
   always_comb begin
      pipe_empty = ~iss_vld_reg;
      for (int i = 0; i < MULT_LATENCY; i++) begin
         if (tag_vld_reg[i]) pipe_empty = 1'b0;
      end
   end

   // Align a returning product to its weight in the 64-bit sum.
   always_comb begin
      case (ret_tag)
         2'd0:    pp_shifted = {32'd0, mc_result};
         2'd3:    pp_shifted = {mc_result, 32'd0};
         default: pp_shifted = {16'd0, mc_result, 16'd0};
      endcase
   end

   // Signed correction of the unsigned high word, then word select.
   always_comb begin
      a_signed    = (op_reg == OP_MULXSS) | (op_reg == OP_MULXSU);
      b_signed    = (op_reg == OP_MULXSS);
      corr_a      = (a_signed & a_reg[31]) ? b_reg : 32'd0;
      corr_b      = (b_signed & b_reg[31]) ? a_reg : 32'd0;
      hi_fixed    = acc_reg[63:32] - corr_a - corr_b;
      result_word = (op_reg == OP_MUL) ? acc_reg[31:0] : hi_fixed;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE:   if (cnt_reg == last_idx) state_next = DRAIN;
         DRAIN:   if (pipe_empty) state_next = FIX;
         FIX:     state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Latch the request and step the issue counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg   <= 32'd0;
         b_reg   <= 32'd0;
         op_reg  <= 2'd0;
         cnt_reg <= 2'd0;
      end else if (accept) begin
         a_reg   <= req_a;
         b_reg   <= req_b;
         op_reg  <= req_op;
         cnt_reg <= 2'd1;
      end else if (state_reg == ISSUE) begin
         cnt_reg <= cnt_reg + 2'd1;
      end
   end

   // Registered cell operands with their tag; idle operands are forced to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         mc_dataa_reg <= 16'd0;
         mc_datab_reg <= 16'd0;
         iss_vld_reg  <= 1'b0;
         iss_tag_reg  <= 2'd0;
      end else begin
         mc_dataa_reg <= issue_en ? issue_a : 16'd0;
         mc_datab_reg <= issue_en ? issue_b : 16'd0;
         iss_vld_reg  <= issue_en;
         iss_tag_reg  <= issue_idx;
      end
   end

   // Tag pipeline following each product through the cell; cleared on reset
   // so products of an abandoned operation are never accumulated.
   genvar gi;
   generate
      for (gi = 0; gi < MULT_LATENCY; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            // First stage takes the tag issued with the operands.
            always_ff @(posedge clk) begin
               if (reset) begin
                  tag_vld_reg[gi] <= 1'b0;
                  tag_reg[gi]     <= 2'd0;
               end else begin
                  tag_vld_reg[gi] <= iss_vld_reg;
                  tag_reg[gi]     <= iss_tag_reg;
               end
            end
         end else begin : g_body
            // Later stages shift the tag one cell cycle further.
            always_ff @(posedge clk) begin
               if (reset) begin
                  tag_vld_reg[gi] <= 1'b0;
                  tag_reg[gi]     <= 2'd0;
               end else begin
                  tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                  tag_reg[gi]     <= tag_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   // Accumulate returning products; a new request starts from zero.
   always_ff @(posedge clk) begin
      if (reset)        acc_reg <= 64'd0;
      else if (accept)  acc_reg <= 64'd0;
      else if (ret_vld) acc_reg <= acc_reg + pp_shifted;
   end

   // Response register: loaded leaving FIX, held until the consumer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= 32'd0;
      end else if (state_reg == FIX) begin
         rsp_valid_reg  <= 1'b1;
         rsp_result_reg <= result_word;
      end else if ((state_reg == RESP) && rsp_ready) begin
         rsp_valid_reg  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl with a behavioural registered 16x16 cell.
// Expected results come from a 64-bit reference product and are queued when
// a request is accepted, then popped when the response appears.
module tb_mul_seq_ctrl;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        busy;
   logic [15:0] mc_dataa;
   logic [15:0] mc_datab;
   logic [31:0] mc_result;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int act_cnt  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cell_q [LAT];

   always #5 clk = ~clk;

   mul_seq_ctrl #(.MULT_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .busy(busy), .mc_dataa(mc_dataa), .mc_datab(mc_datab),
      .mc_result(mc_result)
   );

   // Registered unsigned multiplier cell of latency LAT.
   initial for (int i = 0; i < LAT; i++) cell_q[i] = 32'd0;
   always @(posedge clk) begin
      cell_q[0] <= 32'(mc_dataa) * 32'(mc_datab);
      for (int i = 1; i < LAT; i++) cell_q[i] <= cell_q[i-1];
   end
   assign mc_result = cell_q[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mc_dataa != 16'd0 || mc_datab != 16'd0) act_cnt <= act_cnt + 1;

   function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
      logic [63:0] ea, eb, p;
      ea = {32'd0, a};
      eb = {32'd0, b};
      if (op == 2'b01 || op == 2'b10) ea = {{32{a[31]}}, a};
      if (op == 2'b01) eb = {{32{b[31]}}, b};
      p = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           output bit ok, output int t_acc);
      @(negedge clk);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      ok = 1'b0; t_acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk); #1;
         t_acc = cyc;
         exp_q.push_back(ref_result(a, b, op));
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int t_rsp, output logic [31:0] res);
      ok = 1'b0; t_rsp = 0; res = 32'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; t_rsp = cyc; res = rsp_result; break; end
      end
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output bit ok, output int lat, output logic [31:0] res,
                        output logic [31:0] exp);
      bit ok1, ok2;
      int ta, tr;
      ok = 1'b0; lat = 0; res = 32'd0; exp = 32'd0;
      start_op(a, b, op, ok1, ta);
      if (!ok1) return;
      wait_rsp(ok2, tr, res);
      exp = exp_q.pop_front();
      lat = tr - ta;
      ok  = ok2;
      if (ok2) ack_rsp();
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = 32'd0; req_b = 32'd0; req_op = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
      n_checks++; if ({mc_dataa, mc_datab} !== 32'd0) begin n_fail++; $display("FAIL reset_mc_data: got %h expected 0", {mc_dataa, mc_datab}); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
      $display("test_reset done");
   endtask

   task automatic test_mul_basic();
      bit ok; int lat; logic [31:0] res, exp; int base;
      base = act_cnt;
      do_op(32'h0001_2345, 32'h0000_0010, 2'b00, ok, lat, res, exp);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mul_handshake: got timeout expected response"); end
      n_checks++; if (res !== 32'h0012_3450) begin n_fail++; $display("FAIL mul_result: got %h expected 00123450", res); end
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL mul_scoreboard: got %h expected %h", res, exp); end
      n_checks++; if (lat != 7) begin n_fail++; $display("FAIL mul_latency: got %0d expected 7", lat); end
      n_checks++; if (act_cnt - base != 4) begin n_fail++; $display("FAIL mul_issue_cycles: got %0d expected 4", act_cnt - base); end
      $display("MUL 00012345*00000010 -> %h lat %0d", res, lat);
   endtask

   task automatic test_signed_ops();
      logic [31:0] ta_a [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] ta_b [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [1:0]  t_op [4] = '{2'b11, 2'b01, 2'b10, 2'b01};
      logic [31:0] t_ex [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000};
      for (int i = 0; i < 4; i++) begin
         bit ok; int lat; logic [31:0] res, exp;
         do_op(ta_a[i], ta_b[i], t_op[i], ok, lat, res, exp);
         n_checks++; if (!ok || res !== t_ex[i]) begin n_fail++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, t_ex[i]); end
         n_checks++; if (res !== exp) begin n_fail++; $display("FAIL signed_scoreboard[%0d]: got %h expected %h", i, res, exp); end
         n_checks++; if (lat != 7) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected 7", i, lat); end
         $display("op %b %h*%h -> %h lat %0d", t_op[i], ta_a[i], ta_b[i], res, lat);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         bit ok; int lat; logic [31:0] res, exp; logic [31:0] a, b; logic [1:0] op;
         a = $urandom; b = $urandom; op = 2'(i);
         do_op(a, b, op, ok, lat, res, exp);
         n_checks++; if (!ok || res !== exp) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, exp); end
         $display("b2b op %b %h*%h -> %h", op, a, b, res);
      end
   endtask

   task automatic test_backpressure();
      bit ok; int ta, tr; logic [31:0] res, exp;
      start_op(32'h0000_0003, 32'h0000_0005, 2'b00, ok, ta);
      wait_rsp(ok, tr, res);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_handshake: got timeout expected response"); end
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin req_a = 32'h1234_5678; req_b = 32'h9; req_op = 2'b11; req_valid = 1'b1; end
         if (k == 3) req_valid = 1'b0;
         @(negedge clk);
         n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== res) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", k, rsp_valid, rsp_result, res); end
         n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", k, req_ready); end
      end
      exp = exp_q.pop_front();
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL bp_result: got %h expected %h", res, exp); end
      ack_rsp();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_drop: got %b expected 0", rsp_valid); end
      n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after: got ready %b busy %b expected 1/0", req_ready, busy); end
      $display("backpressure held %h for 5 cycles", res);
   endtask

   task automatic test_reset_mid();
      bit ok; int ta, lat; logic [31:0] res, exp, dropped;
      start_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b01, ok, ta);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_accept: got timeout expected accept"); end
      if (ok) dropped = exp_q.pop_front();
      @(posedge clk); @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp_valid: got %b expected 0", rsp_valid); end
      do_op(32'h0001_0000, 32'h0001_0000, 2'b11, ok, lat, res, exp);
      n_checks++; if (!ok || res !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 00000001", res); end
      n_checks++; if (lat != 7) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected 7", lat); end
      $display("after mid reset MULXUU -> %h lat %0d", res, lat);
   endtask

   task automatic test_shortcut();
      bit ok; int lat; logic [31:0] res, exp; int exp_lat;
`ifdef MUL_SEQ_SHORTCUT_EN
      exp_lat = 6;
`else
      exp_lat = 7;
`endif
      do_op(32'h0000_FFFF, 32'h0000_FFFF, 2'b00, ok, lat, res, exp);
      n_checks++; if (!ok || res !== 32'hFFFE_0001) begin n_fail++; $display("FAIL sc_mul_result: got %h expected fffe0001", res); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL sc_mul_latency: got %0d expected %0d", lat, exp_lat); end
      do_op(32'h0000_FFFF, 32'h0000_FFFF, 2'b11, ok, lat, res, exp);
      n_checks++; if (!ok || res !== 32'h0000_0000) begin n_fail++; $display("FAIL sc_xuu_result: got %h expected 00000000", res); end
      n_checks++; if (lat != 7) begin n_fail++; $display("FAIL sc_xuu_latency: got %0d expected 7", lat); end
      do_op(32'h0000_0000, 32'h8765_4321, 2'b01, ok, lat, res, exp);
      n_checks++; if (!ok || res !== 32'h0 || lat != 7) begin n_fail++; $display("FAIL zero_operand: got %h lat %0d expected 00000000 lat 7", res, lat); end
      $display("shortcut/zero checks done");
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_signed_ops();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_shortcut();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
